// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among N_REQ requesters, with a
// registered valid/ready response channel. Define ALU_ARB_FIXED_PRIO_EN for fixed priority.

module alu #(
  parameter int BW = 16
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [3:0]    opcode,
  output logic [BW-1:0] out,
  output logic [2:0]    flags
);

  logic ovf;

  // 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 shl a by b[3:0], 7 shr a by b[3:0]
  always_comb begin
    out = '0;
    ovf = 1'b0;
    case (opcode)
      4'h0: begin
        out = a + b;
        ovf = (a[BW-1] == b[BW-1]) && (out[BW-1] != a[BW-1]);
      end
      4'h1: begin
        out = a - b;
        ovf = (a[BW-1] != b[BW-1]) && (out[BW-1] != a[BW-1]);
      end
      4'h2:    out = a & b;
      4'h3:    out = a | b;
      4'h4:    out = a ^ b;
      4'h5:    out = ~a;
      4'h6:    out = a << b[3:0];
      4'h7:    out = a >> b[3:0];
      default: out = '0;
    endcase
  end

  assign flags = {ovf, out[BW-1], out == '0};

endmodule

// state | meaning
// IDLE  | waiting for a request; grant is combinational
// EXEC  | operand registers drive the alu for one full cycle
// RESP  | result held on the response channel until rsp_ready
module alu_arbiter #(
  parameter  int BW    = 16,
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*BW-1:0] req_a,
  input  logic [N_REQ*BW-1:0] req_b,
  input  logic [N_REQ*4-1:0]  req_opcode,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [BW-1:0]       rsp_out,
  output logic [2:0]          rsp_flags,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic [IDW-1:0] id_reg;
  logic [BW-1:0]  a_reg, b_reg, out_reg;
  logic [3:0]     op_reg;
  logic [2:0]     flags_reg;
  logic [BW-1:0]  alu_out;
  logic [2:0]     alu_flags;

  logic [BW-1:0] a_arr  [N_REQ];
  logic [BW-1:0] b_arr  [N_REQ];
  logic [3:0]    op_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*BW +: BW];
    assign b_arr[i]  = req_b[i*BW +: BW];
    assign op_arr[i] = req_opcode[i*4 +: 4];
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[IDW'(i)]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] last_grant;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;

  // Scan from farthest to nearest so the requester closest after last_grant wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      scan_sum = {1'b0, last_grant} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(N_REQ)) scan_sum = scan_sum - (IDW+1)'(N_REQ);
      scan_idx = scan_sum[IDW-1:0];
      if (req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end
`endif

  alu #(.BW(BW)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .opcode (op_reg),
    .out    (alu_out),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      id_reg    <= '0;
      out_reg   <= '0;
      flags_reg <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= IDW'(N_REQ - 1);
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_reg  <= a_arr[grant_idx];
            b_reg  <= b_arr[grant_idx];
            op_reg <= op_arr[grant_idx];
            id_reg <= grant_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= grant_idx;
`endif
          end
        end
        EXEC: begin
          out_reg   <= alu_out;
          flags_reg <= alu_flags;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_idx] = 1'b1;
          state_nx             = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign rsp_id    = id_reg;
  assign rsp_out   = out_reg;
  assign rsp_flags = flags_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration and ALU rules.

module tb_alu_arbiter;
  localparam int BW  = 16;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam longint MOD = 64'd1 << BW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*BW-1:0] req_a, req_b;
  logic [N*4-1:0]  req_opcode;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [BW-1:0]   rsp_out;
  logic [2:0]      rsp_flags;
  logic            busy;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] ra [N];
  logic [BW-1:0] rb [N];
  logic [3:0]    ro [N];

  alu_arbiter #(.BW(BW), .N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: {overflow, negative, zero, result} from plain integer arithmetic.
  function automatic logic [BW+2:0] ref_alu(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                           input logic [3:0] op);
    longint ua, ub, sa, sb, r;
    logic [BW-1:0] o;
    logic v;
    ua = a; ub = b;
    sa = (ua >= MOD/2) ? ua - MOD : ua;
    sb = (ub >= MOD/2) ? ub - MOD : ub;
    v = 1'b0;
    r = 0;
    case (op)
      4'h0: begin o = BW'((ua + ub) % MOD); r = sa + sb; v = (r >= MOD/2) || (r < -MOD/2); end
      4'h1: begin o = BW'((ua - ub + MOD) % MOD); r = sa - sb; v = (r >= MOD/2) || (r < -MOD/2); end
      4'h2: o = a & b;
      4'h3: o = a | b;
      4'h4: o = a ^ b;
      4'h5: o = BW'(MOD - 1 - ua);
      4'h6: o = BW'((ua * (64'd1 << ub[3:0])) % MOD);
      4'h7: o = BW'(ua / (64'd1 << ub[3:0]));
      default: o = '0;
    endcase
    return {v, (longint'(o) >= MOD/2), (o == '0), o};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [3:0] op);
    req_a[i*BW +: BW]  = a;
    req_b[i*BW +: BW]  = b;
    req_opcode[i*4 +: 4] = op;
    ra[i] = a; rb[i] = b; ro[i] = op;
  endtask

  task automatic set_rand(input int i);
    set_req(i, BW'($urandom), BW'($urandom), 4'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, '0, '0, '0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_out !== 16'h0) begin errors++; $display("FAIL reset_rsp_out: got %h expected 0000", rsp_out); end
    checks++; if (rsp_flags !== 3'b0) begin errors++; $display("FAIL reset_rsp_flags: got %b expected 000", rsp_flags); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
  endtask

  task automatic test_single();
    logic [BW+2:0] e;
    do_reset();
    set_req(1, 16'h0003, 16'h0004, 4'h0);
    req_valid = 4'b0010; rsp_ready = 1'b1;
    e = ref_alu(16'h0003, 16'h0004, 4'h0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (dut.u_alu.a !== 16'h0003 || dut.u_alu.b !== 16'h0004 || dut.u_alu.opcode !== 4'h0) begin
      errors++; $display("FAIL single_alu_in: got a=%h b=%h op=%h expected 0003 0004 0", dut.u_alu.a, dut.u_alu.b, dut.u_alu.opcode);
    end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_exec: got valid=%b busy=%b expected 0 1", rsp_valid, busy); end
    tick(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL single_rsp: got valid=%b id=%0d expected 1 1", rsp_valid, rsp_id); end
    checks++; if (rsp_out !== e[BW-1:0] || rsp_flags !== e[BW+2:BW]) begin
      errors++; $display("FAIL single_result: got %h/%b expected %h/%b", rsp_out, rsp_flags, e[BW-1:0], e[BW+2:BW]);
    end
    tick(); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    int order [5];
    int g;
    logic [BW+2:0] e;
`ifdef ALU_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int i = 0; i < N; i++) set_rand(i);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      g = order[n];
      e = ref_alu(ra[g], rb[g], ro[g]);
      #1;
      checks++; if (req_ready !== (N'(1) << g)) begin errors++; $display("FAIL rr_grant%0d: got %b expected requester %0d", n, req_ready, g); end
      tick();
      set_rand(g);
      #1;
      checks++; if (req_ready !== 4'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_exec%0d: got ready=%b valid=%b expected 0000 0", n, req_ready, rsp_valid); end
      tick(); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g)) begin errors++; $display("FAIL rr_rsp%0d: got valid=%b id=%0d expected 1 %0d", n, rsp_valid, rsp_id, g); end
      checks++; if (rsp_out !== e[BW-1:0] || rsp_flags !== e[BW+2:BW]) begin
        errors++; $display("FAIL rr_result%0d: got %h/%b expected %h/%b", n, rsp_out, rsp_flags, e[BW-1:0], e[BW+2:BW]);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [BW+2:0] e;
    do_reset();
    set_req(3, 16'h1234, 16'h0F0F, 4'h4);
    e = ref_alu(16'h1234, 16'h0F0F, 4'h4);
    req_valid = 4'b1000; rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant: got %b expected 1000", req_ready); end
    tick();
    set_rand(0);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_exec_ready: got %b expected 0000", req_ready); end
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b busy=%b ready=%b expected 1 1 0000", c, rsp_valid, busy, req_ready);
      end
      checks++; if (rsp_id !== 2'd3 || rsp_out !== e[BW-1:0] || rsp_flags !== e[BW+2:BW]) begin
        errors++; $display("FAIL bp_stable%0d: got id=%0d %h/%b expected 3 %h/%b", c, rsp_id, rsp_out, rsp_flags, e[BW-1:0], e[BW+2:BW]);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b expected 1", rsp_valid); end
    tick(); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_next: got valid=%b busy=%b ready=%b expected 0 0 0001", rsp_valid, busy, req_ready);
    end
    tick();
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_flags();
    logic [BW-1:0] ta [3] = '{16'h7FFF, 16'h0000, 16'h8000};
    logic [BW-1:0] tb [3] = '{16'h0001, 16'h0000, 16'h0001};
    logic [3:0]    to [3] = '{4'h0, 4'h0, 4'h1};
    logic [BW-1:0] xo [3] = '{16'h8000, 16'h0000, 16'h7FFF};
    logic [2:0]    xf [3] = '{3'b110, 3'b001, 3'b100};
    do_reset();
    rsp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_req(2, ta[n], tb[n], to[n]);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      tick(); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_out !== xo[n] || rsp_flags !== xf[n]) begin
        errors++; $display("FAIL flags%0d: got valid=%b id=%0d %h/%b expected 1 2 %h/%b", n, rsp_valid, rsp_id, rsp_out, rsp_flags, xo[n], xf[n]);
      end
      tick();
    end
  endtask

  task automatic test_reset_exec();
    do_reset();
    rsp_ready = 1'b1;
    set_req(2, 16'h00AA, 16'h0055, 4'h3);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_out !== 16'h0 || rsp_flags !== 3'b0) begin
      errors++; $display("FAIL rstexec_state: got busy=%b valid=%b %h/%b expected 0 0 0000/000", busy, rsp_valid, rsp_out, rsp_flags);
    end
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstexec_norsp%0d: got %b expected 0", c, rsp_valid); end
    end
    set_rand(0); set_rand(3);
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstexec_prio: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick();
  endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    rsp_ready = 1'b1;
    set_rand(1); set_rand(3);
    req_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fixed_grant%0d: got %b expected 0010", n, req_ready); end
      tick(); set_rand(1);
      #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL fixed_busy%0d: got %b expected 0000", n, req_ready); end
      tick(); tick();
    end
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL fixed_after_drop: got %b expected 1000", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick();
  endtask
`endif

  task automatic test_random();
    int stage, last, g, mid;
    logic [BW+2:0] mexp;
    logic [N-1:0] exp_ready;
    do_reset();
    stage = 0; last = N - 1; mid = 0; mexp = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin set_rand(i); req_valid[i] = 1'b1; end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      g = (stage == 0) ? pick(req_valid, last) : -1;
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready@%0d: got %b expected %b", c, req_ready, exp_ready); end
      checks++; if (busy !== (stage != 0) || rsp_valid !== (stage == 2)) begin
        errors++; $display("FAIL rand_status@%0d: got busy=%b valid=%b expected stage %0d", c, busy, rsp_valid, stage);
      end
      if (stage == 2) begin
        checks++; if (rsp_id !== IDW'(mid) || rsp_out !== mexp[BW-1:0] || rsp_flags !== mexp[BW+2:BW]) begin
          errors++; $display("FAIL rand_rsp@%0d: got id=%0d %h/%b expected %0d %h/%b", c, rsp_id, rsp_out, rsp_flags, mid, mexp[BW-1:0], mexp[BW+2:BW]);
        end
      end
      if (stage == 0 && g >= 0) begin
        mid = g; mexp = ref_alu(ra[g], rb[g], ro[g]);
`ifndef ALU_ARB_FIXED_PRIO_EN
        last = g;
`endif
        stage = 1;
      end else if (stage == 1) begin
        stage = 2;
      end else if (stage == 2 && rsp_ready) begin
        stage = 0;
      end
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_opcode = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flags();
    test_reset_exec();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance (BW-bit operands, 4-bit opcode, flags {overflow, negative, zero}) among N_REQ requesters.
- Arbitration is round-robin.
- Each granted operation is registered into the ALU, and the ALU result plus flags are captured.
- The result is returned on a single response channel with valid/ready handshake, tagged with the requester ID.
- Sits between the issuing units and the ALU. The `alu` is instantiated inside this block.

Parameters:
- BW, 16, operand/result bitwidth, passed to `alu`.
- N_REQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(N_REQ), requester ID width; derived, not overridable.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester request valid
- req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero
- req_a  input  N_REQ*BW  operand A, requester i at bits [i*BW +: BW]
- req_b  input  N_REQ*BW  operand B, same packing
- req_opcode  input  N_REQ*4  opcode, requester i at bits [i*4 +: 4]
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accepted by sink
- rsp_id  output  IDW  index of the requester that issued the operation
- rsp_out  output  BW  ALU result
- rsp_flags  output  3  ALU flags {overflow, negative, zero}
- busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - Operand, opcode, result, flag and ID registers are cleared to 0.
  - last_grant=N_REQ-1, so requester 0 has top priority after reset.
  - Outputs after reset: rsp_valid=0, req_ready=0, busy=0, rsp_out=0, rsp_flags=0, rsp_id=0.
  - Reset mid-operation aborts the operation: no response is produced and the captured operation is discarded.
- IDLE:
  - Grant index g = first i with req_valid[i]=1, scanning last_grant+1, last_grant+2, ... modulo N_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - At the clock edge: latch req_a[g], req_b[g], req_opcode[g] into the operand registers; id_reg=g; last_grant=g; go to EXEC.
  - No req_valid: stay in IDLE, req_ready=0.
- EXEC:
  - The operand registers drive the alu a full cycle.
  - At the clock edge: capture alu out and flags into result registers; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_id, rsp_out and rsp_flags are driven from registers and stay stable while rsp_valid=1 and rsp_ready=0.
  - rsp_ready=1: response accepted at that edge; go to IDLE.
  - req_ready=0 throughout RESP.
- Latency: grant at cycle T, rsp_valid rises at T+2.
- Minimum issue interval: 3 cycles per operation.
- Requester rules:
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - A requester dropping req_valid before grant is legal; nothing is latched for it.
- Operands are not modified by this block. All arithmetic, including overflow and flag semantics, is the alu's.
- Starvation-free: a continuously valid requester is granted within N_REQ grants.
- A single requester that is always valid is granted back-to-back, every 3 cycles.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index with req_valid=1 wins; last_grant is unused and not updated.
- Undefined (default): round-robin as described in Behaviour.
- All other timing and handshake behaviour is identical in both builds.

Test Plan:
- Reset, then single request:
  - Stimulus: req_valid=4'b0010, req_a[1]=16'h0003, req_b[1]=16'h0004, req_opcode[1]=4'h0.
  - Required: req_ready=4'b0010 in the same cycle.
  - Required: the alu sees a=3, b=4, opcode=0 in EXEC.
  - Required: rsp_valid=1 two cycles after the grant, with rsp_id=1, and rsp_out/rsp_flags equal to the reference alu output for those operands.
- All four requesters held valid, rsp_ready=1:
  - Required: grant order 0,1,2,3,0.
  - Required: responses every 3 cycles with rsp_id matching that order.
- Backpressure, rsp_ready=0 for 5 cycles while in RESP:
  - Required: rsp_valid stays 1.
  - Required: rsp_out, rsp_flags and rsp_id stay unchanged.
  - Required: req_ready=0 and busy=1 throughout.
  - Required: on rsp_ready=1, return to IDLE and the next grant follows one cycle later.
- Overflow/zero propagation:
  - Stimulus: requester 2 issues an opcode and operands that produce an alu overflow, e.g. a=16'h7FFF, b=16'h0001 with the add opcode.
  - Required: rsp_flags equals the alu flags, e.g. 3'b110 for overflow+negative.
  - Stimulus: a=b=16'h0000 with the add opcode.
  - Required: rsp_flags[0]=1.
- Reset in EXEC:
  - Stimulus: assert rst while in EXEC.
  - Required: the next cycle has state IDLE, rsp_valid=0, busy=0, and no response is ever produced for that operation.
  - Required: with req_valid=4'b1001 afterwards, requester 0 is granted first.
- ALU_ARB_FIXED_PRIO_EN defined, req_valid=4'b1010 held:
  - Required: requester 1 is granted repeatedly.
  - Required: requester 3 is never granted until req_valid[1] drops.
